// File: rtl/tdc_hit_sequencer.sv
// Arm/gate/readout sequencer for one tapped-delay-line TDC channel.
// Optional `TDC_BUBBLE_CORR_EN selects a popcount fine decode instead of leading-ones.
module tdc_hit_sequencer #(
  parameter int unsigned NTAPS    = 32,
  parameter int unsigned COARSE_W = 16,
  parameter int unsigned FINE_W   = 6,
  parameter int unsigned DEADTIME = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic [NTAPS-1:0]    tap_in,
  output logic                dl_gate,
  output logic                meas_valid,
  input  logic                meas_ready,
  output logic [COARSE_W-1:0] meas_coarse,
  output logic [FINE_W-1:0]   meas_fine,
  output logic                meas_timeout,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + DEADTIME + 2);

  typedef enum logic [2:0] {
    StIdle, StFlush, StArmed, StCapture, StEncode, StOutput, StDead
  } state_e;

  state_e              state_q;
  logic [COARSE_W-1:0] coarse_q, csnap_q, meas_coarse_q;
  logic [NTAPS-1:0]    tap_q1, tap_q2, snap_q;
  logic [CntW-1:0]     cnt_q;
  logic [FINE_W-1:0]   fine_d, meas_fine_q;
  logic                dl_gate_q, valid_q, timeout_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse_q <= '0;
      tap_q1   <= '0;
      tap_q2   <= '0;
    end else begin
      coarse_q <= coarse_q + COARSE_W'(1);
      tap_q1   <= tap_in;
      tap_q2   <= tap_q1;
    end
  end

  always_comb begin
    fine_d = '0;
`ifdef TDC_BUBBLE_CORR_EN
    for (int i = 0; i < int'(NTAPS); i++) begin
      fine_d = fine_d + FINE_W'(snap_q[i]);
    end
`else
    // Scan downwards so the lowest-index zero wins.
    fine_d = FINE_W'(NTAPS);
    for (int i = int'(NTAPS) - 1; i >= 0; i--) begin
      if (!snap_q[i]) fine_d = FINE_W'(i);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      snap_q        <= '0;
      csnap_q       <= '0;
      dl_gate_q     <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      meas_coarse_q <= '0;
      meas_fine_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_q   <= StFlush;
            cnt_q     <= '0;
            dl_gate_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StFlush: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= StArmed;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StArmed: begin
          if (tap_q2[0]) begin
            state_q   <= StCapture;
            snap_q    <= tap_q2;
            // tap_q2 lags the gate input by two clocks.
            csnap_q   <= coarse_q - COARSE_W'(2);
            dl_gate_q <= 1'b0;
          end else if (!arm) begin
            state_q   <= StIdle;
            dl_gate_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q       <= StOutput;
            dl_gate_q     <= 1'b0;
            valid_q       <= 1'b1;
            timeout_q     <= 1'b1;
            meas_fine_q   <= '0;
            meas_coarse_q <= coarse_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StCapture: state_q <= StEncode;
        StEncode: begin
          state_q       <= StOutput;
          valid_q       <= 1'b1;
          timeout_q     <= 1'b0;
          meas_fine_q   <= fine_d;
          meas_coarse_q <= csnap_q;
        end
        StOutput: begin
          if (meas_ready) begin
            state_q <= StDead;
            valid_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StDead: begin
          if (cnt_q == CntW'(DEADTIME - 1)) begin
            cnt_q <= '0;
            if (arm) begin
              state_q   <= StFlush;
              dl_gate_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dl_gate      = dl_gate_q;
  assign meas_valid   = valid_q;
  assign meas_coarse  = meas_coarse_q;
  assign meas_fine    = meas_fine_q;
  assign meas_timeout = timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Self-checking bench for tdc_hit_sequencer: timestamp-based phase model plus directed literals.
// Honours `TDC_BUBBLE_CORR_EN for the bubbled-code expectation.
module tb_tdc_hit_sequencer;

  localparam int TIMEOUT  = 1000;
  localparam int DEADTIME = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic [31:0] tap_in;
  logic        dl_gate;
  logic        meas_valid;
  logic        meas_ready;
  logic [15:0] meas_coarse;
  logic [5:0]  meas_fine;
  logic        meas_timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  tdc_hit_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .tap_in       (tap_in),
    .dl_gate      (dl_gate),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .meas_coarse  (meas_coarse),
    .meas_fine    (meas_fine),
    .meas_timeout (meas_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Model: n is the current cycle since reset release (equals the coarse count),
  // t_mark is the start cycle of the current phase (or the cycle valid is due).
  typedef enum int {PIdle, PFlush, PArmed, PWait, POut, PDead} phase_e;
  phase_e      ph;
  int          n;
  int          t_mark;
  logic [31:0] p1, p2;
  logic [15:0] r_coarse;
  logic [5:0]  r_fine;
  logic        r_to;

  function automatic int model_fine(input logic [31:0] w);
`ifdef TDC_BUBBLE_CORR_EN
    return $countones(w);
`else
    logic [32:0] x;
    x = {1'b0, w} + 33'd1;
    return $countones(w & ~x[31:0]);
`endif
  endfunction

  task automatic model_reset();
    n  = 0;
    p1 = '0;
    p2 = '0;
    ph = PIdle;
    t_mark = 0;
  endtask

  task automatic model_step();
    case (ph)
      PIdle: if (arm) begin ph = PFlush; t_mark = n + 1; end
      PFlush: if (n + 1 == t_mark + 2) begin ph = PArmed; t_mark = n + 1; end
      PArmed: begin
        if (p2[0]) begin
          r_coarse = 16'(n - 2);
          r_fine   = 6'(model_fine(p2));
          r_to     = 1'b0;
          ph       = PWait;
          t_mark   = n + 3;
        end else if (!arm) begin
          ph = PIdle;
        end else if (n - t_mark == TIMEOUT - 1) begin
          r_coarse = 16'(n);
          r_fine   = '0;
          r_to     = 1'b1;
          ph       = POut;
        end
      end
      PWait: if (n + 1 == t_mark) ph = POut;
      POut: if (meas_ready) begin ph = PDead; t_mark = n + 1; end
      PDead: begin
        if (n + 1 == t_mark + DEADTIME) begin
          if (arm) begin ph = PFlush; t_mark = n + 1; end
          else ph = PIdle;
        end
      end
      default: ph = PIdle;
    endcase
    p2 = p1;
    p1 = tap_in;
    n  = n + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic compare_outputs();
    chk("dl_gate", 32'(dl_gate), 32'((ph == PFlush || ph == PArmed) ? 1 : 0));
    chk("busy", 32'(busy), 32'((ph != PIdle) ? 1 : 0));
    chk("meas_valid", 32'(meas_valid), 32'((ph == POut) ? 1 : 0));
    if (ph == POut) begin
      chk("meas_coarse", 32'(meas_coarse), 32'(r_coarse));
      chk("meas_fine", 32'(meas_fine), 32'(r_fine));
      chk("meas_timeout", 32'(meas_timeout), 32'(r_to));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !meas_valid; i++) tick();
    if (!meas_valid) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL wait_valid: meas_valid still 0 after %0d cycles (cycle %0d)", max, n);
    end
  endtask

  task automatic wait_armed();
    for (int i = 0; i < 200 && ph != PArmed; i++) tick();
    chk("wait_armed", 32'(ph), 32'(PArmed));
  endtask

  task automatic directed_hit(input string name, input logic [31:0] word, input int exp);
    wait_armed();
    tap_in = word;
    tick();
    tap_in = '0;
    wait_valid(10);
    chk(name, 32'(meas_fine), 32'(exp));
    chk("hit_timeout_flag", 32'(meas_timeout), 32'd0);
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_gate"}, 32'(dl_gate), 32'd0);
    chk({name, "_valid"}, 32'(meas_valid), 32'd0);
    chk({name, "_coarse"}, 32'(meas_coarse), 32'd0);
    chk({name, "_fine"}, 32'(meas_fine), 32'd0);
    chk({name, "_timeout"}, 32'(meas_timeout), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s_coarse;
    logic [5:0]  s_fine;
    int          a0;
    int          t;

    rst_n = 1'b0; arm = 1'b0; tap_in = '0; meas_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Hit first seen in tap_q2 at coarse 200.
    arm = 1'b1;
    while (n < 198) tick();
    tap_in = 32'h0000_00FF;
    tick();
    tap_in = '0;
    while (n < 202) tick();
    chk("lat_not_yet_valid", 32'(meas_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(meas_valid), 32'd1);
    chk("lit_coarse_198", 32'(meas_coarse), 32'd198);
    chk("lit_fine_8", 32'(meas_fine), 32'd8);
    chk("lit_timeout_0", 32'(meas_timeout), 32'd0);
    s_coarse = meas_coarse;
    s_fine   = meas_fine;
    repeat (10) tick();
    chk("stall_valid", 32'(meas_valid), 32'd1);
    chk("stall_coarse", 32'(meas_coarse), 32'(s_coarse));
    chk("stall_fine", 32'(meas_fine), 32'(s_fine));

    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    chk("valid_drop", 32'(meas_valid), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      chk("gate_after_ready", 32'(dl_gate), 32'((i <= 4) ? 0 : 1));
      tick();
    end

    directed_hit("fine_all_ones", 32'hFFFF_FFFF, 32);
    directed_hit("fine_one", 32'h0000_0001, 1);
`ifdef TDC_BUBBLE_CORR_EN
    directed_hit("fine_bubble", 32'h0000_00F7, 7);
`else
    directed_hit("fine_bubble", 32'h0000_00F7, 3);
`endif

    // Timeout record.
    wait_armed();
    a0 = n;
    wait_valid(1100);
    chk("timeout_latency", 32'(n), 32'(a0 + 1000));
    chk("timeout_flag", 32'(meas_timeout), 32'd1);
    chk("timeout_fine", 32'(meas_fine), 32'd0);
    chk("timeout_coarse", 32'(meas_coarse), 32'(16'(a0 + 999)));
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;

    // Arm dropped while armed.
    wait_armed();
    repeat (3) tick();
    arm = 1'b0;
    tick();
    chk("armdrop_gate", 32'(dl_gate), 32'd0);
    chk("armdrop_busy", 32'(busy), 32'd0);
    arm = 1'b1;

    // Reset while a record is pending.
    wait_armed();
    tap_in = 32'h0000_0003;
    tick();
    tap_in = '0;
    wait_valid(10);
    chk("pre_reset_valid", 32'(meas_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    arm = 1'b0;

    // Coarse wrap: hit sampled at coarse 1 after one full wrap.
    while (n < 65535) begin
      tap_in = (n < 65520) ? $urandom() : 32'd0;
      arm    = (n >= 65530);
      tick();
    end
    tap_in = 32'h0000_0001;
    tick();
    tap_in = '0;
    wait_valid(10);
    chk("wrap_latency", 32'(n), 32'd65540);
    chk("wrap_coarse", 32'(meas_coarse), 32'h0000_FFFF);
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;

    // Randomised traffic.
    arm = 1'b1;
    for (int c = 0; c < 12000; c++) begin
      if ($urandom_range(0, 99) < 4) begin
        int          k;
        logic [63:0] tw;
        k  = $urandom_range(1, 32);
        tw = (64'd1 << k) - 64'd1;
        tap_in = tw[31:0];
        if ($urandom_range(0, 3) == 0) tap_in[$urandom_range(1, 31)] ^= 1'b1;
      end else begin
        tap_in    = $urandom();
        tap_in[0] = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) arm = ~arm;
      meas_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_hit_sequencer.md
Name: tdc_hit_sequencer

Overview:
- Controller that arms, gates and reads out the tapped delay line (NTAPS taps) for one TDC channel.
- Opens the delay-line input gate and registers the tap thermometer word every clk.
- Detects the first tap-0 transition, freezes the snapshot plus a free-running coarse count, and decodes a {coarse, fine} timestamp.
- Delivers the timestamp through a valid/ready handshake, then enforces a dead-time before re-arming.

Parameters:
NTAPS, 32, number of delay-line taps (width of tap_in)
COARSE_W, 16, width of the free-running coarse counter
FINE_W, 6, width of fine field; must satisfy 2^FINE_W > NTAPS
DEADTIME, 4, clk cycles dl_gate is held low after each readout
TIMEOUT, 1000, max clk cycles in ARMED before a timeout record is produced

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
arm  in  1  level; high = channel enabled for acquisition
tap_in  in  NTAPS  raw delay-line thermometer outputs (asynchronous to clk)
dl_gate  out  1  enable ANDed with the filtered hit at the delay-line input
meas_valid  out  1  timestamp record available
meas_ready  in  1  consumer accepts the record when high with meas_valid
meas_coarse  out  COARSE_W  coarse time of hit
meas_fine  out  FINE_W  fine code (count of set taps)
meas_timeout  out  1  record is a timeout, not a hit
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: dl_gate=0, meas_valid=0, meas_coarse=0, meas_fine=0, meas_timeout=0, busy=0.
  - Internal: coarse counter=0, tap pipeline=0, FSM=IDLE.
  - Reset mid-operation discards any pending record.
- Coarse counter: increments every clk from reset and wraps modulo 2^COARSE_W; never stops.
- Tap pipeline: tap_q1 <= tap_in, tap_q2 <= tap_q1 every clk, in all states.
- FSM states:
  - IDLE: dl_gate=0. If arm=1, go to FLUSH.
  - FLUSH: dl_gate=1 for 2 cycles; tap_q2 is ignored. Then go to ARMED and clear the timeout counter.
  - ARMED: dl_gate=1.
    - tap_q2[0]=1 in cycle k: go to CAPTURE.
    - arm=0 (lower priority than a hit in the same cycle): go to IDLE next cycle.
    - Timeout counter reaches TIMEOUT-1: go to OUTPUT with meas_timeout=1, meas_fine=0, meas_coarse=current count.
  - CAPTURE (cycle k+1):
    - Snapshot register <= tap_q2 of cycle k.
    - coarse_snap <= coarse count of cycle k minus 2, modulo 2^COARSE_W (pipeline compensation).
    - dl_gate=0.
  - ENCODE (cycle k+2): meas_fine <= decode(snapshot), meas_coarse <= coarse_snap, meas_timeout=0.
  - OUTPUT: meas_valid=1 from cycle k+3. Outputs are stable while meas_valid=1 and meas_ready=0. Transfer when meas_valid and meas_ready are both high, then go to DEAD.
  - DEAD: dl_gate=0 for DEADTIME cycles. Then go to FLUSH if arm=1, else IDLE.
- Deassertion of arm during CAPTURE/ENCODE/OUTPUT/DEAD does not abort; the record is still delivered.
- Default decode (leading-ones): meas_fine = index of first 0 scanning from tap 0. All ones gives NTAPS; tap0=0 is impossible in CAPTURE.
- meas_ready is ignored outside OUTPUT.

Optional Feature:
- Macro TDC_BUBBLE_CORR_EN.
- Defined: meas_fine = popcount of the snapshot. Tolerant to bubbles (isolated 0/1 errors) in the thermometer code.
- Undefined: leading-ones decode as above; bubbles truncate the code.

Test Plan:
- Reset then arm=1; tap_in=0x0000_00FF first seen in tap_q2 at coarse count 200 -> meas_valid 3 cycles later with meas_coarse=198, meas_fine=8, meas_timeout=0.
- tap_in=0xFFFF_FFFF when ARMED -> meas_fine=32. tap_in=0x0000_0001 -> meas_fine=1.
- Bubbled tap_in=0x0000_00F7 -> meas_fine=3 without TDC_BUBBLE_CORR_EN, 7 with it.
- Hold meas_ready=0 for 10 cycles after meas_valid -> all meas_* stable. Ready pulse -> valid drops next cycle; dl_gate stays 0 for 4 cycles, then FLUSH 2 cycles, then ARMED.
- arm=1, no hit for 1000 cycles -> record with meas_timeout=1, meas_fine=0. Coarse wrap: hit sampled at coarse 1 -> meas_coarse=0xFFFF.
- arm dropped in ARMED -> IDLE next cycle, dl_gate=0, busy=0. rst_n pulsed low during OUTPUT -> meas_valid=0 immediately, coarse counter=0.
